// File: rtl/gate_unit_arbiter.sv
// Round-robin arbiter that time-shares one registered gate/half-adder unit among NUM_REQ requesters.
// Build option: define GATE_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.

module gate_unit_arbiter_gate #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        op,
    output logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] carry,
    output logic              err
);
    always_comb begin
        data  = '0;
        carry = '0;
        err   = 1'b0;
        case (op)
            3'd0: data = a & b;
            3'd1: data = a | b;
            3'd2: data = a ^ b;
            3'd3: data = ~(a & b);
            3'd4: data = ~(a | b);
            3'd5: begin
                data  = a ^ b;
                carry = a & b;
            end
            default: err = 1'b1;
        endcase
    end
endmodule

module gate_unit_arbiter_lane #(
    parameter int IDX_W = 2,
    parameter int LANE  = 0
) (
    input  logic             req_bit,
    input  logic             win_found,
    input  logic [IDX_W-1:0] win_idx,
    output logic             gnt_bit
);
    assign gnt_bit = win_found && req_bit && (win_idx == IDX_W'(LANE));
endmodule

module gate_unit_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] op_a,
    input  logic [NUM_REQ*DATA_W-1:0] op_b,
    input  logic [NUM_REQ*3-1:0]      op_sel,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [IDX_W-1:0]          res_id,
    output logic [DATA_W-1:0]         res_data,
    output logic [DATA_W-1:0]         res_carry,
    output logic                      res_err
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [IDX_W:0]   NR_W     = (IDX_W+1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ-1);

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [2:0]        op;
        logic [IDX_W-1:0]  id;
    } op_req_t;

    logic [1:0]                     state;
    logic [IDX_W-1:0]               ptr;
    op_req_t                        lat;

    logic [NUM_REQ-1:0][DATA_W-1:0] a_vec;
    logic [NUM_REQ-1:0][DATA_W-1:0] b_vec;
    logic [NUM_REQ-1:0][2:0]        sel_vec;

    logic [2*NUM_REQ-1:0]           req2;
    logic [NUM_REQ-1:0]             rot;
    logic [IDX_W-1:0]               off;
    logic [IDX_W:0]                 sum;
    logic [IDX_W:0]                 win_sum;
    logic [IDX_W-1:0]               win_idx;
    logic                           win_found;
    logic [IDX_W-1:0]               ptr_next;
    logic [NUM_REQ-1:0]             gnt_next;

    logic [DATA_W-1:0]              calc_data;
    logic [DATA_W-1:0]              calc_carry;
    logic                           calc_err;

    assign a_vec   = op_a;
    assign b_vec   = op_b;
    assign sel_vec = op_sel;

    // Rotate req so that ptr sits at bit 0; the first set bit is then the offset from ptr.
    assign req2 = {req, req};
    assign rot  = req2[ptr +: NUM_REQ];

    always_comb begin
        win_found = 1'b0;
        off       = '0;
        for (int k = NUM_REQ-1; k >= 0; k--) begin
            if (rot[k]) begin
                win_found = 1'b1;
                off       = IDX_W'(k);
            end
        end
    end

    assign sum     = {1'b0, ptr} + {1'b0, off};
    assign win_sum = (sum >= NR_W) ? (sum - NR_W) : sum;
    assign win_idx = win_sum[IDX_W-1:0];

`ifdef GATE_ARB_FIXED_PRIO_EN
    // With ptr pinned at 0 the rotation is the identity, so lowest index wins.
    assign ptr_next = '0;
`else
    assign ptr_next = (win_idx == LAST_IDX) ? '0 : (win_idx + IDX_W'(1));
`endif

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        gate_unit_arbiter_lane #(
            .IDX_W (IDX_W),
            .LANE  (i)
        ) u_lane (
            .req_bit   (req[i]),
            .win_found (win_found),
            .win_idx   (win_idx),
            .gnt_bit   (gnt_next[i])
        );
    end

    gate_unit_arbiter_gate #(
        .DATA_W (DATA_W)
    ) u_gate (
        .a     (lat.a),
        .b     (lat.b),
        .op    (lat.op),
        .data  (calc_data),
        .carry (calc_carry),
        .err   (calc_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            lat       <= '0;
            gnt       <= '0;
            res_valid <= 1'b0;
            res_id    <= '0;
            res_data  <= '0;
            res_carry <= '0;
            res_err   <= 1'b0;
        end else begin
            gnt <= '0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        lat.a  <= a_vec[win_idx];
                        lat.b  <= b_vec[win_idx];
                        lat.op <= sel_vec[win_idx];
                        lat.id <= win_idx;
                        gnt    <= gnt_next;
                        ptr    <= ptr_next;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    res_data  <= calc_data;
                    res_carry <= calc_carry;
                    res_err   <= calc_err;
                    res_id    <= lat.id;
                    res_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    // Result fields stay put after consumption; only valid drops.
                    if (res_valid && res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gate_unit_arbiter.sv
// Directed bench for gate_unit_arbiter; expectations follow GATE_ARB_FIXED_PRIO_EN when defined.

module tb_gate_unit_arbiter;
    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int IDX_W   = 2;
`ifdef GATE_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic                      clk;
    logic                      rst_n;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] op_a;
    logic [NUM_REQ*DATA_W-1:0] op_b;
    logic [NUM_REQ*3-1:0]      op_sel;
    logic [NUM_REQ-1:0]        gnt;
    logic                      res_valid;
    logic                      res_ready;
    logic [IDX_W-1:0]          res_id;
    logic [DATA_W-1:0]         res_data;
    logic [DATA_W-1:0]         res_carry;
    logic                      res_err;

    int passed = 0;
    int total  = 0;

    gate_unit_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_sel    (op_sel),
        .gnt       (gnt),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_data  (res_data),
        .res_carry (res_carry),
        .res_err   (res_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic set_op(input int idx, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        op_sel[idx*3 +: 3]      = op;
        op_a[idx*DATA_W +: DATA_W] = a;
        op_b[idx*DATA_W +: DATA_W] = b;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_gnt"},   32'(gnt),       32'h0);
        chk({tag, "_valid"}, 32'(res_valid), 32'h0);
        chk({tag, "_id"},    32'(res_id),    32'h0);
        chk({tag, "_data"},  32'(res_data),  32'h0);
        chk({tag, "_carry"}, 32'(res_carry), 32'h0);
        chk({tag, "_err"},   32'(res_err),   32'h0);
    endtask

    // Grant tick, result tick, consume tick (res_ready must be 1 for the last).
    task automatic run_op(input string tag, input logic [3:0] exp_gnt, input logic [1:0] exp_id,
                          input logic [7:0] exp_data, input logic [7:0] exp_carry, input logic exp_err,
                          input logic [3:0] req_after);
        tick();
        chk({tag, "_gnt"}, 32'(gnt), 32'(exp_gnt));
        req = req_after;
        tick();
        chk({tag, "_gnt_low"}, 32'(gnt),       32'h0);
        chk({tag, "_valid"},   32'(res_valid), 32'h1);
        chk({tag, "_id"},      32'(res_id),    32'(exp_id));
        chk({tag, "_data"},    32'(res_data),  32'(exp_data));
        chk({tag, "_carry"},   32'(res_carry), 32'(exp_carry));
        chk({tag, "_err"},     32'(res_err),   32'(exp_err));
        tick();
        chk({tag, "_consumed"}, 32'(res_valid), 32'h0);
    endtask

    logic [1:0] fair_id [6];
    logic [7:0] fair_data [4];

    initial begin
        rst_n = 1'b0; req = '0; res_ready = 1'b0;
        op_a = '0; op_b = '0; op_sel = '0;
        #2;
        chk_zero("reset");
        tick(); tick();
        rst_n = 1'b1;
        res_ready = 1'b1;

        // Fairness: distinct ops per requester so data also identifies the owner.
        set_op(0, 3'd0, 8'hF0, 8'h3C);   // AND  -> 30
        set_op(1, 3'd1, 8'hF0, 8'h3C);   // OR   -> FC
        set_op(2, 3'd3, 8'hAA, 8'hFF);   // NAND -> 55
        set_op(3, 3'd4, 8'h0F, 8'h30);   // NOR  -> C0
        fair_data = '{8'h30, 8'hFC, 8'h55, 8'hC0};
        fair_id   = FIXED ? '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0}
                          : '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        req = 4'b1111;
        for (int n = 0; n < 6; n++) begin
            run_op($sformatf("fair%0d", n), 4'(1 << fair_id[n]), fair_id[n],
                   fair_data[fair_id[n]], 8'h00, 1'b0, (n == 5) ? 4'b0000 : 4'b1111);
        end

        // XOR on requester 0; in round-robin ptr is 2 here, so the search wraps.
        set_op(0, 3'd2, 8'hF0, 8'h3C);
        req = 4'b0001;
        run_op("xor", 4'b0001, 2'd0, 8'hCC, 8'h00, 1'b0, 4'b0000);

        set_op(2, 3'd5, 8'hFF, 8'h01);
        req = 4'b0100;
        run_op("hadd", 4'b0100, 2'd2, 8'hFE, 8'h01, 1'b0, 4'b0000);

        set_op(3, 3'd7, 8'hFF, 8'hFF);
        req = 4'b1000;
        run_op("illegal", 4'b1000, 2'd3, 8'h00, 8'h00, 1'b1, 4'b0000);

        // Backpressure with req = 0011 held; ptr is 0 in either build.
        set_op(1, 3'd1, 8'hF0, 8'h3C);
        req = 4'b0011;
        res_ready = 1'b0;
        tick();
        chk("bp_gnt", 32'(gnt), 32'h1);
        tick();
        chk("bp_valid", 32'(res_valid), 32'h1);
        chk("bp_data",  32'(res_data),  32'hCC);
        for (int n = 0; n < 5; n++) begin
            tick();
            chk($sformatf("bp_hold_valid%0d", n), 32'(res_valid), 32'h1);
            chk($sformatf("bp_hold_data%0d", n),  32'(res_data),  32'hCC);
            chk($sformatf("bp_hold_gnt%0d", n),   32'(gnt),       32'h0);
        end
        res_ready = 1'b1;
        tick();
        chk("bp_release", 32'(res_valid), 32'h0);
        chk("bp_data_kept", 32'(res_data), 32'hCC);
        run_op("bp_next", FIXED ? 4'b0001 : 4'b0010, FIXED ? 2'd0 : 2'd1,
               FIXED ? 8'hCC : 8'hFC, 8'h00, 1'b0, 4'b0000);

        // Async reset in the middle of RESP, away from any clock edge.
        req = 4'b0001;
        res_ready = 1'b0;
        tick();
        chk("mid_gnt", 32'(gnt), 32'h1);
        req = 4'b0000;
        tick();
        chk("mid_valid", 32'(res_valid), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        rst_n = 1'b1;
        res_ready = 1'b1;
        // ptr back at 0: 0101 must go to requester 0 rather than 2.
        req = 4'b0101;
        run_op("post_rst", 4'b0001, 2'd0, 8'hCC, 8'h00, 1'b0, 4'b0000);
        req = 4'b0100;
        run_op("post_rst2", 4'b0100, 2'd2, 8'hFE, 8'h01, 1'b0, 4'b0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
